usb_pkt_tx: RTL
===============

// Module: usb_pkt_tx
// PURPOSE
// - UTMI transmit engine: sends one USB packet (PID, payload, optional CRC16) on the UTMI tx port of ulpi_wrapper.
// - Byte-stream source upstream (ftdi_if register path or a tx buffer); replaces the tied-off utmi_txvalid/utmi_data of the capture top.
// - Transmit counterpart of the usb_sniffer receive path.
// PARAMETERS
// - LEN_W       11  payload length counter width in bytes (max 2047)
// - IPG_CYCLES  8   idle clocks enforced after a packet before next start is accepted (>=1)
// PORTS
// - clk_i           in   1      60MHz ULPI clock; the only clock
// - rst_i           in   1      reset, synchronous, active-low
// - start_i         in   1      request: send packet described by pid_i/len_i
// - pid_i           in   4      PID; sent as {~pid_i,pid_i}
// - len_i           in   LEN_W  payload bytes following PID
// - data_i          in   8      payload byte
// - data_valid_i    in   1      data_i valid
// - data_accept_o   out  1      data_i consumed this cycle (valid & accept)
// - busy_o          out  1      packet in progress or gap running
// - done_o          out  1      1-cycle pulse: last byte taken by PHY
// - error_o         out  1      1-cycle pulse: payload underrun, packet aborted
// - utmi_data_o     out  8      UTMI tx byte
// - utmi_txvalid_o  out  1      UTMI tx valid
// - utmi_txready_i  in   1      UTMI tx ready (byte taken when valid & ready)
// BEHAVIOUR
// - Reset (rst_i=0 at edge): state IDLE; all outputs 0; hold register empty; CRC=16'hFFFF. Mid-packet reset drops txvalid at that edge.
// - States: IDLE -> PID -> DATA -> CRC_LO -> CRC_HI -> GAP -> IDLE.
// - IDLE: start_i=1 latches pid_i,len_i, remaining=len_i; next cycle PID. start_i ignored outside IDLE.
// - PID: txvalid=1, data={~pid,pid}; stays until txready. Prefetches first payload byte into hold register if len!=0.
// - On PID accepted: len!=0 -> DATA; len==0 & crc_pkt -> CRC_LO; else -> GAP with done_o.
// - crc_pkt = (pid[1:0]==2'b11) (DATA0/1/2, MDATA). Non-data PIDs send len raw bytes, no CRC (tokens carry caller CRC5).
// - Hold register: 1 byte; data_accept_o = data_valid_i & state in {PID,DATA} & bytes_fetched<len & (hold empty | (DATA & txready)). Zero-bubble streaming at txready=1.
// - DATA: utmi_data_o=hold byte, txvalid=1. utmi_data_o changes only the cycle after a valid&ready handshake; never while stalled.
// - Underrun: in DATA with hold empty -> txvalid=0 next cycle, error_o pulse, no done_o, -> GAP.
// - Last payload byte accepted: crc_pkt -> CRC_LO, else -> GAP with done_o.
// - CRC16: init 16'hFFFF, reflected poly 16'hA001, LSB-first, updated per payload byte on PHY acceptance. Sent inverted: CRC_LO={~crc[7:0]}, CRC_HI={~crc[15:8]}. CRC_HI accepted -> GAP, done_o.
// - GAP: txvalid=0, counts IPG_CYCLES then IDLE. busy_o=1 from start acceptance through GAP end.
// - Error and done never pulse together; exactly one per accepted start (unless reset).
// CONFIGURATION
// - USB_TX_CRC16_EN defined: CRC16 generated/appended for data PIDs as above.
// - USB_TX_CRC16_EN undefined: no CRC logic; CRC_LO/CRC_HI unreachable; all PIDs send len raw bytes (caller supplies CRC); crc_pkt treated as 0.
// TESTING
// - ACK: start pid=4'h2 len=0, txready=1 -> one byte 8'hD2, done_o next, busy_o low after IPG_CYCLES.
// - DATA0 len=0 (CRC_EN) -> bytes C3,00,00 in 3 back-to-back cycles; done_o after last.
// - DATA1 len=4 {00,01,02,03}, txready=1, source always valid -> 4B,00,01,02,03,CRC_LO,CRC_HI with no gaps; CRC matches bench model (0xA001, init FFFF, inverted).
// - Same DATA1 with txready toggling 1/0 -> each byte held stable while txready=0; identical byte sequence.
// - DATA0 len=3, data_valid_i drops after byte 1 -> txvalid low, error_o pulse, no done_o, returns IDLE.
// - rst_i=0 mid-DATA -> next cycle txvalid=0, busy_o=0, data_accept_o=0; new start then sends a clean packet.

Source files
------------

// File: rtl/usb_pkt_tx_if.sv
// Upstream byte-source and UTMI transmit signals of usb_pkt_tx.
// slave: the transmit engine; master: the byte source / PHY side driving it.
interface usb_pkt_tx_if #(
  parameter int unsigned LEN_W = 11
);
  logic             start_i;
  logic [3:0]       pid_i;
  logic [LEN_W-1:0] len_i;
  logic [7:0]       data_i;
  logic             data_valid_i;
  logic             data_accept_o;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  logic [7:0]       utmi_data_o;
  logic             utmi_txvalid_o;
  logic             utmi_txready_i;

  modport master (
    output start_i, pid_i, len_i, data_i, data_valid_i, utmi_txready_i,
    input  data_accept_o, busy_o, done_o, error_o, utmi_data_o, utmi_txvalid_o
  );

  modport slave (
    input  start_i, pid_i, len_i, data_i, data_valid_i, utmi_txready_i,
    output data_accept_o, busy_o, done_o, error_o, utmi_data_o, utmi_txvalid_o
  );
endinterface

// File: rtl/usb_pkt_tx.sv
// UTMI transmit engine: PID, payload and (with USB_TX_CRC16_EN defined) CRC16 for data PIDs.
// A one-byte hold register doubles as the DATA-phase output byte, giving zero-bubble streaming.
module usb_pkt_tx #(
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned IPG_CYCLES = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  usb_pkt_tx_if.slave  bus
);
  localparam int unsigned GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [LEN_W-1:0] fetched_q, fetched_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             txvalid_q, txvalid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_hs;
  logic             accept_c;
  logic             crc_pkt;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_pkt_q, crc_pkt_d;

  // Reflected CRC16 (poly 0xA001), one byte LSB-first
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_pkt = crc_pkt_q;
`else
  assign crc_pkt = 1'b0;
`endif

  assign tx_hs    = txvalid_q & bus.utmi_txready_i;
  assign accept_c = bus.data_valid_i
                  & ((state_q == S_PID) | (state_q == S_DATA))
                  & (fetched_q < len_q)
                  & (~hold_full_q | ((state_q == S_DATA) & tx_hs));

  assign bus.data_accept_o  = accept_c;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.utmi_data_o    = tx_data_q;
  assign bus.utmi_txvalid_o = txvalid_q;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      remaining_q <= '0;
      fetched_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      txvalid_q   <= 1'b0;
      tx_data_q   <= '0;
`ifdef USB_TX_CRC16_EN
      crc_q       <= 16'hFFFF;
      crc_pkt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      fetched_q   <= fetched_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      txvalid_q   <= txvalid_d;
      tx_data_q   <= tx_data_d;
`ifdef USB_TX_CRC16_EN
      crc_q       <= crc_d;
      crc_pkt_q   <= crc_pkt_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    fetched_d   = fetched_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    gap_d       = gap_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    txvalid_d   = 1'b0;
    tx_data_d   = tx_data_q;
`ifdef USB_TX_CRC16_EN
    crc_d       = crc_q;
    crc_pkt_d   = crc_pkt_q;
`endif

    // Hold register: drained by a DATA handshake, refilled by an accept in the same cycle
    if ((state_q == S_DATA) && tx_hs) hold_full_d = 1'b0;
    if (accept_c) begin
      fetched_d   = fetched_q + LEN_W'(1);
      hold_d      = bus.data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d     = S_PID;
          len_d       = bus.len_i;
          remaining_d = bus.len_i;
          fetched_d   = '0;
          hold_full_d = 1'b0;
          busy_d      = 1'b1;
          txvalid_d   = 1'b1;
          tx_data_d   = {~bus.pid_i, bus.pid_i};
`ifdef USB_TX_CRC16_EN
          crc_d       = 16'hFFFF;
          crc_pkt_d   = (bus.pid_i[1:0] == 2'b11);
`endif
        end
      end

      S_PID: begin
        txvalid_d = 1'b1;
        if (tx_hs) begin
          if (len_q != '0) begin
            if (hold_full_d) begin
              state_d   = S_DATA;
              tx_data_d = hold_d;
            end else begin
              state_d   = S_GAP;
              txvalid_d = 1'b0;
              error_d   = 1'b1;
              gap_d     = '0;
            end
          end else if (crc_pkt) begin
            state_d = S_CRC_LO;
`ifdef USB_TX_CRC16_EN
            tx_data_d = ~crc_q[7:0];
`endif
          end else begin
            state_d   = S_GAP;
            txvalid_d = 1'b0;
            done_d    = 1'b1;
            gap_d     = '0;
          end
        end
      end

      S_DATA: begin
        txvalid_d = 1'b1;
        if (tx_hs) begin
          remaining_d = remaining_q - LEN_W'(1);
`ifdef USB_TX_CRC16_EN
          crc_d = crc16_upd(crc_q, hold_q);
`endif
          if (remaining_q == LEN_W'(1)) begin
            if (crc_pkt) begin
              state_d = S_CRC_LO;
`ifdef USB_TX_CRC16_EN
              tx_data_d = ~crc_d[7:0];
`endif
            end else begin
              state_d   = S_GAP;
              txvalid_d = 1'b0;
              done_d    = 1'b1;
              gap_d     = '0;
            end
          end else if (hold_full_d) begin
            tx_data_d = hold_d;
          end else begin
            // Source could not keep up: abort the packet
            state_d   = S_GAP;
            txvalid_d = 1'b0;
            error_d   = 1'b1;
            gap_d     = '0;
          end
        end
      end

`ifdef USB_TX_CRC16_EN
      S_CRC_LO: begin
        txvalid_d = 1'b1;
        if (tx_hs) begin
          state_d   = S_CRC_HI;
          tx_data_d = ~crc_q[15:8];
        end
      end

      S_CRC_HI: begin
        txvalid_d = 1'b1;
        if (tx_hs) begin
          state_d   = S_GAP;
          txvalid_d = 1'b0;
          done_d    = 1'b1;
          gap_d     = '0;
        end
      end
`endif

      S_GAP: begin
        if (gap_q == GAP_W'(IPG_CYCLES - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end
endmodule
